// File: rtl/hex_disp_pkg.sv
// Segment codes (gfedcba, active-low) shared by the hex scan driver and its decoder.
package hex_disp_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/hex_scan_driver_if.sv
// Display bundle between the timer/counter side (master) and the scan driver (slave).
interface hex_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 6
) ();

    logic                      en;
    logic [4*NUM_DIGITS-1:0]   digits_in;
    logic [NUM_DIGITS-1:0]     blank_mask;
    logic [NUM_DIGITS-1:0]     blink_mask;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic                      lzs_en;
    logic [6:0]                seg_n;
    logic                      dp_n;
    logic [NUM_DIGITS-1:0]     an_n;
    logic                      frame_tick;

    modport master (
        output en, digits_in, blank_mask, blink_mask, dp_mask, lzs_en,
        input  seg_n, dp_n, an_n, frame_tick
    );

    modport slave (
        input  en, digits_in, blank_mask, blink_mask, dp_mask, lzs_en,
        output seg_n, dp_n, an_n, frame_tick
    );

endinterface

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low 7-segment decoder; codes 10-15 optional.
module hex_seg_decode
    import hex_disp_pkg::*;
#(
    parameter int unsigned HEX_EN = 1
) (
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_n_o
);

    // Lookup of the segment pattern for one nibble
    always_comb begin
        seg_n_o = SEG_BLANK;
        case (nibble_i)
            4'h0:    seg_n_o = SEG_0;
            4'h1:    seg_n_o = SEG_1;
            4'h2:    seg_n_o = SEG_2;
            4'h3:    seg_n_o = SEG_3;
            4'h4:    seg_n_o = SEG_4;
            4'h5:    seg_n_o = SEG_5;
            4'h6:    seg_n_o = SEG_6;
            4'h7:    seg_n_o = SEG_7;
            4'h8:    seg_n_o = SEG_8;
            4'h9:    seg_n_o = SEG_9;
            4'hA:    seg_n_o = (HEX_EN != 0) ? SEG_A : SEG_BLANK;
            4'hB:    seg_n_o = (HEX_EN != 0) ? SEG_B : SEG_BLANK;
            4'hC:    seg_n_o = (HEX_EN != 0) ? SEG_C : SEG_BLANK;
            4'hD:    seg_n_o = (HEX_EN != 0) ? SEG_D : SEG_BLANK;
            4'hE:    seg_n_o = (HEX_EN != 0) ? SEG_E : SEG_BLANK;
            4'hF:    seg_n_o = (HEX_EN != 0) ? SEG_F : SEG_BLANK;
            default: seg_n_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/hex_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with frame-coherent snapshot,
// leading-zero suppression, per-digit blank/blink and decimal point.
module hex_scan_driver
    import hex_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 6,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DEAD_CYCLES  = 2,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned HEX_EN       = 1
) (
    input  logic                clk,
    input  logic                rst,
    hex_scan_driver_if.slave    disp
);

    localparam int unsigned DIG_W  = 4 * NUM_DIGITS;
    localparam int unsigned PRE_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
    logic                  phase_q, phase_d;

    logic [DIG_W-1:0]      shadow_q;
    logic [NUM_DIGITS-1:0] blank_q, blink_q, dp_q;
    logic                  lzs_q;

    logic [6:0]            seg_q, seg_d;
    logic                  dp_n_q, dp_n_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  tick_q, tick_d;

    logic                  pre_wrap, frame_wrap;
    logic [3:0]            cur_nib;
    logic                  cur_blank, cur_blink, cur_dp, cur_lz;
    logic [NUM_DIGITS-1:0] lz_vec;
    logic                  lz_run;
    logic [6:0]            dec_seg;
    logic                  dark, suppress;

    assign pre_wrap   = (pre_q == PRE_W'(SCAN_DIV - 1));
    assign frame_wrap = pre_wrap && (idx_q == IDX_W'(NUM_DIGITS - 1));

    // Next values for prescaler, digit index and blink counter/phase
    always_comb begin
        pre_d   = pre_wrap ? '0 : pre_q + PRE_W'(1);
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (pre_wrap) begin
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        if (frame_wrap) begin
            if (bcnt_q == BCNT_W'(BLINK_FRAMES - 1)) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BCNT_W'(1);
            end
        end
    end

    // Scan timing state
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q   <= '0;
            idx_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    // Inputs are captured only at the frame wrap so a frame never tears
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            blank_q  <= '0;
            blink_q  <= '0;
            dp_q     <= '0;
            lzs_q    <= 1'b0;
        end else if (frame_wrap) begin
            shadow_q <= disp.digits_in;
            blank_q  <= disp.blank_mask;
            blink_q  <= disp.blink_mask;
            dp_q     <= disp.dp_mask;
            lzs_q    <= disp.lzs_en;
        end
    end

    // Select the current digit's attributes and its leading-zero status
    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_dp    = 1'b0;
        cur_lz    = 1'b0;
        lz_vec    = '0;
        lz_run    = 1'b1;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            lz_run    = lz_run & (shadow_q[4*k +: 4] == 4'h0);
            lz_vec[k] = lz_run;
        end
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_nib   = shadow_q[4*k +: 4];
                cur_blank = blank_q[k];
                cur_blink = blink_q[k];
                cur_dp    = dp_q[k];
                cur_lz    = lz_vec[k];
            end
        end
    end

    hex_seg_decode #(
        .HEX_EN (HEX_EN)
    ) u_dec (
        .nibble_i (cur_nib),
        .seg_n_o  (dec_seg)
    );

    // Next output pattern; dark conditions override everything
    always_comb begin
        an_d     = '1;
        seg_d    = SEG_BLANK;
        dp_n_d   = 1'b1;
        tick_d   = frame_wrap;
        dark     = !disp.en || (pre_q < PRE_W'(DEAD_CYCLES)) || cur_blank
                   || (cur_blink && phase_q);
        suppress = lzs_q && (idx_q != '0) && cur_lz;
        if (!dark) begin
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                an_d[k] = !(idx_q == IDX_W'(k));
            end
            seg_d  = suppress ? SEG_BLANK : dec_seg;
            dp_n_d = !cur_dp;
        end
    end

    // Registered pin drivers
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q   <= '1;
            seg_q  <= SEG_BLANK;
            dp_n_q <= 1'b1;
            tick_q <= 1'b0;
        end else begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
            tick_q <= tick_d;
        end
    end

    assign disp.an_n       = an_q;
    assign disp.seg_n      = seg_q;
    assign disp.dp_n       = dp_n_q;
    assign disp.frame_tick = tick_q;

endmodule
